// File: rtl/ctrl_pkg.sv
// Shared encodings for the 16-bit multicycle processor: opcodes, ALU
// operations, datapath mux selects and the control FSM state type.
package ctrl_pkg;

    // Instruction opcodes, instr[15:12]; 8..15 are undefined.
    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_ORI   = 4'd2;
    localparam logic [3:0] OP_LW    = 4'd3;
    localparam logic [3:0] OP_SW    = 4'd4;
    localparam logic [3:0] OP_BEQ   = 4'd5;
    localparam logic [3:0] OP_J     = 4'd6;
    localparam logic [3:0] OP_HALT  = 4'd7;

    // ALU operation encodings.
    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_SLT   = 3'd4;
    localparam logic [2:0] ALU_PASSB = 3'd5;

    // ALU B-input select.
    localparam logic [1:0] SRCB_REG    = 2'd0;
    localparam logic [1:0] SRCB_TWO    = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    // PC source select.
    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    // Immediate extender mode.
    localparam logic EXT_SIGN = 1'b0;
    localparam logic EXT_ZERO = 1'b1;

    // Control FSM states.
    typedef enum logic [3:0] {
        RST,
        FETCH,
        DECODE,
        R_EX,
        R_WB,
        I_EX,
        I_WB,
        MADDR,
        MRD,
        MWB,
        MWR,
        BR,
        JMP,
        HALT
    } state_t;

    // R-type funct to ALU op: 0..5 pass straight through, 6 and 7 fold to ADD.
    function automatic logic [2:0] funct_to_alu(input logic [2:0] f);
        return (f > 3'd5) ? ALU_ADD : f;
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback
// over the shared datapath and drives every mux select and enable.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned OPW = 4,
    parameter int unsigned FW  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic        ext_sel,
    output logic        illegal,
    output logic        halted
);

    state_t           state;
    logic [OPW-1:0]   op;
    logic [FW-1:0]    funct;
    logic             unused_ir_bits;

    assign op    = instr[15 -: OPW];
    assign funct = instr[FW-1:0];

    // Register-specifier and immediate fields belong to the datapath.
    assign unused_ir_bits = ^instr[15-OPW:FW];

    // State register and next-state sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST;
        end else begin
            case (state)
                RST:    state <= FETCH;
                FETCH:  if (mem_ready) state <= DECODE;
                DECODE: begin
                    case (op)
                        OPW'(OP_RTYPE): state <= R_EX;
                        OPW'(OP_ADDI),
                        OPW'(OP_ORI):   state <= I_EX;
                        OPW'(OP_LW),
                        OPW'(OP_SW):    state <= MADDR;
                        OPW'(OP_BEQ):   state <= BR;
                        OPW'(OP_J):     state <= JMP;
                        OPW'(OP_HALT):  state <= HALT;
                        default:        state <= FETCH;
                    endcase
                end
                R_EX:   state <= R_WB;
                R_WB:   state <= FETCH;
                I_EX:   state <= I_WB;
                I_WB:   state <= FETCH;
                // Only LW and SW reach MADDR; the IR still holds the opcode.
                MADDR:  state <= (op == OPW'(OP_SW)) ? MWR : MRD;
                MRD:    if (mem_ready) state <= MWB;
                MWB:    state <= FETCH;
                MWR:    if (mem_ready) state <= FETCH;
                BR:     state <= FETCH;
                JMP:    state <= FETCH;
                HALT:   state <= HALT;
                default: state <= RST;
            endcase
        end
    end

    // Output decode from the current state. Every mem_ready/alu_zero/instr
    // term is qualified by a state, so RST and HALT stay strobe-free.
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        ext_sel    = EXT_SIGN;
        illegal    = 1'b0;
        halted     = 1'b0;
        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_TWO;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                illegal   = op[OPW-1];
            end
            R_EX: begin
                alu_src_a = 1'b1;
                alu_op    = funct_to_alu(3'(funct));
            end
            R_WB, I_WB: begin
                reg_write = 1'b1;
            end
            I_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                if (op == OPW'(OP_ORI)) begin
                    alu_op  = ALU_OR;
                    ext_sel = EXT_ZERO;
                end
            end
            MADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            MRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            MWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            BR: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PC_SRC_ALUOUT;
                pc_write  = alu_zero;
            end
            JMP: begin
                pc_write = 1'b1;
                pc_src   = PC_SRC_JUMP;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
